// File: rtl/fb_scheduler_if.sv
// Shadow-buffer loader handshake between the frame-bucket scheduler and the bucket loader.
interface fb_scheduler_if #(
   parameter int unsigned FB_ADDR_WIDTH = 20
);
   logic                     load_req;
   logic [FB_ADDR_WIDTH-1:0] load_addr;
   logic                     load_ack;

   modport master (output load_req, output load_addr, input load_ack);
   modport slave  (input load_req, input load_addr, output load_ack);
endinterface

// File: rtl/fb_scheduler.sv
// Frame-bucket scheduler: counts display rotations, preloads the next bucket into the
// shadow buffer and issues a rotation-aligned swap strobe to the renderer.
module fb_scheduler #(
   parameter int unsigned FB_IDX_WIDTH  = 8,
   parameter int unsigned ROT_CNT_WIDTH = 16,
   parameter int unsigned FB_ADDR_WIDTH = 20,
   parameter int unsigned FB_WORDS      = 4096
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     clock_cycle,
   input  logic [FB_IDX_WIDTH-1:0]  num_fb,
   input  logic [ROT_CNT_WIDTH-1:0] rot_per_fb,
   input  logic                     hold,
   input  logic                     step,
   fb_scheduler_if.master           load,
   output logic                     clock_next_fb,
   output logic [FB_IDX_WIDTH-1:0]  fb_index,
   output logic                     fb_valid,
   output logic                     underrun
);

   localparam int unsigned CNT_EXT_W = ROT_CNT_WIDTH + 1;
   localparam logic [FB_ADDR_WIDTH-1:0] WORDS_STEP = FB_ADDR_WIDTH'(FB_WORDS);

   typedef enum logic [1:0] {S_BOOT, S_READY, S_PRELOAD} state_t;

   state_t                   state, state_d;
   logic                     cycle_prev;
   logic                     boot, boot_d;
   logic                     step_pending, step_pending_d;
   logic [ROT_CNT_WIDTH-1:0] rot_cnt, rot_cnt_d;
   logic [FB_IDX_WIDTH-1:0]  next_idx, next_idx_d;
   logic [FB_ADDR_WIDTH-1:0] next_base, next_base_d;

   logic                     load_req_d;
   logic [FB_ADDR_WIDTH-1:0] load_addr_d;
   logic                     clock_next_fb_d, fb_valid_d, underrun_d;
   logic [FB_IDX_WIDTH-1:0]  fb_index_d;

   logic                     rot_edge, ack, due, swap;
   logic [FB_IDX_WIDTH-1:0]  last_idx;
   logic [ROT_CNT_WIDTH-1:0] dwell;
   logic [CNT_EXT_W-1:0]     cnt_inc;

   // State and all registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= S_BOOT;
         cycle_prev     <= 1'b1;
         boot           <= 1'b0;
         step_pending   <= 1'b0;
         rot_cnt        <= '0;
         next_idx       <= '0;
         next_base      <= '0;
         load.load_req  <= 1'b0;
         load.load_addr <= '0;
         clock_next_fb  <= 1'b0;
         fb_index       <= '0;
         fb_valid       <= 1'b0;
         underrun       <= 1'b0;
      end else begin
         state          <= state_d;
         cycle_prev     <= clock_cycle;
         boot           <= boot_d;
         step_pending   <= step_pending_d;
         rot_cnt        <= rot_cnt_d;
         next_idx       <= next_idx_d;
         next_base      <= next_base_d;
         load.load_req  <= load_req_d;
         load.load_addr <= load_addr_d;
         clock_next_fb  <= clock_next_fb_d;
         fb_index       <= fb_index_d;
         fb_valid       <= fb_valid_d;
         underrun       <= underrun_d;
      end
   end

   // Next-state, swap decision and output values
   always_comb begin
      state_d         = state;
      boot_d          = boot;
      step_pending_d  = step_pending;
      rot_cnt_d       = rot_cnt;
      next_idx_d      = next_idx;
      next_base_d     = next_base;
      clock_next_fb_d = 1'b0;
      underrun_d      = 1'b0;
      fb_index_d      = fb_index;
      fb_valid_d      = fb_valid;

      rot_edge = clock_cycle & ~cycle_prev;
      ack      = load.load_req & load.load_ack;
      last_idx = (num_fb == '0) ? '0 : num_fb - FB_IDX_WIDTH'(1);
      dwell    = (rot_per_fb == '0) ? ROT_CNT_WIDTH'(1) : rot_per_fb;
      cnt_inc  = {1'b0, rot_cnt} + CNT_EXT_W'(1);
      due      = step_pending | (~hold & (cnt_inc >= {1'b0, dwell}));
      swap     = (state == S_READY) & rot_edge & (boot | due);

      case (state)
         S_BOOT: begin
            if (ack) begin
               state_d = S_READY;
               boot_d  = 1'b1;
            end
         end
         S_READY: begin
            if (swap) state_d = S_PRELOAD;
         end
         S_PRELOAD: begin
            if (ack) state_d = S_READY;
         end
         default: state_d = S_BOOT;
      endcase

      if (swap) begin
         clock_next_fb_d = 1'b1;
         fb_index_d      = next_idx;
         fb_valid_d      = 1'b1;
         rot_cnt_d       = '0;
         boot_d          = 1'b0;
         step_pending_d  = 1'b0;
         if (next_idx >= last_idx) begin
            next_idx_d  = '0;
            next_base_d = '0;
         end else begin
            next_idx_d  = next_idx + FB_IDX_WIDTH'(1);
            next_base_d = next_base + WORDS_STEP;
         end
      end else if (rot_edge) begin
         // A due edge with the shadow buffer still loading is reported, not swapped
         if (due & (state != S_READY)) underrun_d = 1'b1;
         if (rot_cnt != '1) rot_cnt_d = rot_cnt + ROT_CNT_WIDTH'(1);
      end

      // A step seen on the swap cycle itself requests the following edge
      if (step) step_pending_d = 1'b1;

      // Request is raised one cycle after entering a loading state, dropped after ack
      load_req_d = (state != S_READY) & ~ack;
      case (state)
         S_BOOT:    load_addr_d = '0;
         S_PRELOAD: load_addr_d = next_base;
         default:   load_addr_d = load.load_addr;
      endcase
   end

endmodule

// File: doc/fb_scheduler.md
# fb_scheduler

Frame-bucket scheduler for the rotating-display pipeline. It counts display rotations from the `clock_cycle` sync input and decides when the renderer switches to the next frame bucket. It preloads each upcoming bucket into the shadow buffer through a req/ack handshake to the bucket loader. It drives the renderer's `clock_next_fb` swap strobe, aligned to a rotation edge.

## Interface
- FB_IDX_WIDTH, 8: width of the bucket index.
- ROT_CNT_WIDTH, 16: width of the rotation dwell counter.
- FB_ADDR_WIDTH, 20: width of the loader word address.
- FB_WORDS, 4096: words per bucket; bucket n base address = n*FB_WORDS mod 2^FB_ADDR_WIDTH.

Ports:
- clock  in  1  system clock; all logic posedge.
- reset  in  1  synchronous, active-high reset.
- clock_cycle  in  1  rotation sync level; each rising edge = one revolution.
- num_fb  in  FB_IDX_WIDTH  number of buckets in the animation; 0 treated as 1.
- rot_per_fb  in  ROT_CNT_WIDTH  rotations to dwell per bucket; 0 treated as 1.
- hold  in  1  freeze on the current bucket (no timed advance).
- step  in  1  one-cycle request to advance at the next rotation edge, even while hold.
- load_req  out  1  shadow-buffer load request.
- load_addr  out  FB_ADDR_WIDTH  base address of the bucket to load; stable while load_req=1.
- load_ack  in  1  loader completion; sampled only while load_req=1.
- clock_next_fb  out  1  one-cycle swap strobe to the renderer.
- fb_index  out  FB_IDX_WIDTH  index of the bucket now displayed.
- fb_valid  out  1  at least one swap has occurred since reset.
- underrun  out  1  one-cycle pulse: swap was due but the shadow load was not finished.

## Operation
- Edge detect: rot_edge = clock_cycle & ~cycle_prev. On reset, cycle_prev is set to 1 so a level already high at reset is not an edge.
- State machine:
  - BOOT: load_req=1, load_addr=0. On ack, go to READY with boot flag set.
  - READY: the shadow buffer holds bucket next_idx. On rot_edge with (boot | due), swap and go to PRELOAD.
  - PRELOAD: load_req=1, load_addr=next_base. On ack, go to READY.
- Swap actions (one cycle):
  - clock_next_fb=1; fb_index<=next_idx; fb_valid<=1; rot_cnt<=0; boot<=0; step_pending<=0.
  - Advance next_idx: if next_idx >= eff_num-1, set next_idx<=0 and next_base<=0. Otherwise next_idx+1 and next_base+FB_WORDS.
  - eff_num = max(num_fb,1).
- Due rule at rot_edge: due = step_pending | (~hold & (rot_cnt+1 >= max(rot_per_fb,1))).
  - With rot_per_fb=3, the swap happens on the 3rd edge after the previous swap.
- rot_cnt increments by 1 on every non-swap rot_edge, saturating at all-ones.
- step: any cycle with step=1 sets step_pending; it is cleared only by a swap.
- Underrun: rot_edge with due=1 while in PRELOAD (or BOOT) gives a one-cycle underrun pulse and no swap. The due condition is re-evaluated at later edges; step_pending persists.
- num_fb/rot_per_fb changes take effect at the next evaluation. If num_fb shrinks below next_idx+1, the next advance wraps to 0.
- num_fb=1: every swap reloads bucket 0 (the same address each time).

## Timing
- Reset values:
  - Outputs: clock_next_fb=0, underrun=0, fb_index=0, fb_valid=0.
  - load_req=1 and load_addr=0 from the first cycle after reset (BOOT).
  - Internal: rot_cnt=0, next_idx=0, next_base=0, step_pending=0.
- All outputs are registered.
- clock_next_fb and underrun go high in the cycle after the clock edge that first samples clock_cycle high.
- fb_index updates in the same cycle as clock_next_fb.
- load_req for the following preload rises in the cycle after the swap strobe. load_addr is valid in that same cycle.
- Ack handshake:
  - Ack sampled high with req high completes the transfer; load_req drops in the next cycle.
  - Ack while req is low is ignored.
- Minimum gap between swaps is one rotation edge. Load latency must be below one rotation period to avoid underrun.
- Reset asserted mid-load abandons the request: load_req is 0 for every cycle reset is held, then returns to BOOT. The loader must tolerate the abandonment.
- Simultaneous ack and rot_edge in PRELOAD: counts as underrun; READY is entered, and the swap occurs at the next edge if still due.

## Test plan
- Boot: reset, ack after 5 cycles, then rot_edge. Required: load_addr=0, one clock_next_fb pulse, fb_index=0, fb_valid=1, and load_req rises next cycle with load_addr=FB_WORDS.
- Dwell and wrap: num_fb=3, rot_per_fb=2, immediate acks, 8 rotation edges after boot. Required: fb_index sequence 0,1,2,0 with swaps on every 2nd edge.
- Hold/step: rot_per_fb=1 with hold=1, 4 edges. Required: no swaps. Then one step pulse: exactly one swap at the next edge.
- Underrun: ack withheld across 2 due edges. Required: 2 underrun pulses and no swap. Ack, then next edge: swap, fb_index advanced by 1.
- Edge-at-reset: clock_cycle high during reset and released. Required: no rot_edge until clock_cycle goes low then high.
- Zero config: num_fb=0, rot_per_fb=0. Required: behaves as 1/1 (a swap every edge, fb_index stays 0, load_addr always 0).
